// File: rtl/stage4_mem.sv
`default_nettype none
// ============================================================================
// Module   : stage4_mem
// Purpose  : Pipeline MEM stage with a handshaked data-memory port, stall
//            generation, bounded ack wait and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module stage4_mem #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic        regwrite,
    input  logic [31:0] alurslt,
    input  logic [31:0] wdata,
    input  logic [4:0]  wrreg,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        regwrite_out,
    output logic        memtoreg_out,
    output logic [31:0] rdata,
    output logic [31:0] alurslt_out,
    output logic [4:0]  wrreg_out,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;

    logic [31:0] r_hold_addr, r_hold_wdata;
    logic [4:0]  r_hold_wrreg;
    logic        r_hold_we, r_hold_rw, r_hold_mtr;

    logic        r_regwrite, r_memtoreg;
    logic [31:0] r_rdata, r_alurslt;
    logic [4:0]  r_wrreg;
    logic        r_misalign, r_timeout;

    logic        w_memop, w_misalign, w_capture, w_stall, w_set_mis, w_set_to;
    logic        w_wb_rw, w_wb_mtr;
    logic [31:0] w_wb_rdata, w_wb_alu;
    logic [4:0]  w_wb_wr;

    assign w_memop    = ex_valid & (memread | memwrite);
    assign w_misalign = (alurslt[1:0] != 2'b00);

    // MEM/WB defaults to a bubble; only completing instructions override it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_stall     = 1'b0;
        w_set_mis   = 1'b0;
        w_set_to    = 1'b0;
        w_wb_rw     = 1'b0;
        w_wb_mtr    = 1'b0;
        w_wb_rdata  = 32'd0;
        w_wb_alu    = 32'd0;
        w_wb_wr     = 5'd0;
        case (r_state)
            IDLE: begin
                if (w_memop) begin
                    if (w_misalign) begin
                        w_set_mis = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_capture   = 1'b1;
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = WAIT;
                    end
                end else if (ex_valid) begin
                    w_wb_rw  = regwrite;
                    w_wb_mtr = memtoreg;
                    w_wb_alu = alurslt;
                    w_wb_wr  = wrreg;
                end
            end
            WAIT: begin
                if (dm_ack) begin
                    w_wb_rw     = r_hold_rw & ~r_hold_we;
                    w_wb_mtr    = r_hold_mtr;
                    w_wb_rdata  = r_hold_we ? 32'd0 : dm_rdata;
                    w_wb_alu    = r_hold_addr;
                    w_wb_wr     = r_hold_wrreg;
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_last) begin
                    w_set_to    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    w_stall   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_hold_addr  <= 32'd0;
            r_hold_wdata <= 32'd0;
            r_hold_wrreg <= 5'd0;
            r_hold_we    <= 1'b0;
            r_hold_rw    <= 1'b0;
            r_hold_mtr   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_rdata      <= 32'd0;
            r_alurslt    <= 32'd0;
            r_wrreg      <= 5'd0;
            r_misalign   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_regwrite <= w_wb_rw;
            r_memtoreg <= w_wb_mtr;
            r_rdata    <= w_wb_rdata;
            r_alurslt  <= w_wb_alu;
            r_wrreg    <= w_wb_wr;
            if (w_capture) begin
                r_hold_addr  <= alurslt;
                r_hold_wdata <= wdata;
                r_hold_wrreg <= wrreg;
                r_hold_we    <= memwrite;
                r_hold_rw    <= regwrite;
                r_hold_mtr   <= memtoreg;
            end
            if (w_set_mis) r_misalign <= 1'b1;
            if (w_set_to)  r_timeout  <= 1'b1;
        end
    end

    // Gated by reset_n so stall drops at once even while EX/MEM still holds a memop.
    assign stall        = reset_n & w_stall;
    assign dm_req       = (r_state == WAIT);
    assign dm_we        = dm_req & r_hold_we;
    assign dm_addr      = dm_req ? {r_hold_addr[31:2], 2'b00} : 32'd0;
    assign dm_wdata     = dm_req ? r_hold_wdata : 32'd0;
    assign regwrite_out = r_regwrite;
    assign memtoreg_out = r_memtoreg;
    assign rdata        = r_rdata;
    assign alurslt_out  = r_alurslt;
    assign wrreg_out    = r_wrreg;
    assign misalign_err = r_misalign;
    assign timeout_err  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_stage4_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage4_mem
// Purpose  : Directed scoreboard bench for stage4_mem (TIMEOUT=4 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage4_mem;

    logic        clk, reset_n;
    logic        ex_valid, memread, memwrite, memtoreg, regwrite;
    logic [31:0] alurslt, wdata, dm_rdata;
    logic [4:0]  wrreg;
    logic        stall, dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, rdata, alurslt_out;
    logic        regwrite_out, memtoreg_out, misalign_err, timeout_err;
    logic [4:0]  wrreg_out;

    int checks = 0;
    int errors = 0;
    logic [70:0] exp_q[$];

    stage4_mem #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .memread(memread),
        .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
        .alurslt(alurslt), .wdata(wdata), .wrreg(wrreg), .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .regwrite_out(regwrite_out),
        .memtoreg_out(memtoreg_out), .rdata(rdata), .alurslt_out(alurslt_out),
        .wrreg_out(wrreg_out), .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every non-bubble MEM/WB word must match the head of the queue.
    always @(negedge clk) begin
        logic [70:0] act;
        act = {regwrite_out, memtoreg_out, rdata, alurslt_out, wrreg_out};
        if (reset_n && act != 71'd0) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", act, 71'd0);
            end else begin
                chk("wb_word", act, exp_q.pop_front());
            end
        end
    end

    task automatic clear_inputs();
        ex_valid = 0; memread = 0; memwrite = 0; memtoreg = 0; regwrite = 0;
        alurslt = 0; wdata = 0; wrreg = 0; dm_ack = 0; dm_rdata = 0;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that retires the op.
    task automatic run_memop(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [4:0] dst, input logic rw,
                             input logic mtr, input int ack_at, input logic [31:0] rd_data,
                             output int req_cyc, output int stall_cyc);
        int  widx;
        bit  done;
        ex_valid = 1; memread = rd; memwrite = wr; alurslt = addr; wdata = wd;
        wrreg = dst; regwrite = rw; memtoreg = mtr;
        req_cyc = 0; stall_cyc = 0; widx = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            dm_ack   = dm_req && (widx == ack_at);
            dm_rdata = dm_ack ? rd_data : 32'hBAD0BAD0;
            @(negedge clk);
            if (dm_req) begin
                req_cyc++;
                chk("dm_addr", 71'(dm_addr), 71'({addr[31:2], 2'b00}));
                chk("dm_we", 71'(dm_we), 71'(wr));
                chk("dm_wdata", 71'(dm_wdata), 71'(wd));
                widx++;
            end
            if (stall) stall_cyc++;
            done = !stall;
            @(posedge clk); #1;
        end
        if (!done) chk("memop_retire_bound", 71'd0, 71'd1);
        clear_inputs();
    endtask

    initial begin
        int rq, st;
        reset_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb", {regwrite_out, memtoreg_out, rdata, alurslt_out, wrreg_out}, 71'd0);
        chk("rst_ctl", {stall, dm_req, dm_we, misalign_err, timeout_err}, 71'd0);
        chk("rst_dm", {dm_addr, dm_wdata}, 71'd0);
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;

        // ALU op with a stray ack in IDLE
        exp_q.push_back({1'b1, 1'b0, 32'd0, 32'h10, 5'd3});
        ex_valid = 1; alurslt = 32'h10; wrreg = 3; regwrite = 1; dm_ack = 1;
        @(negedge clk);
        chk("alu_stall", 71'(stall), 71'd0);
        chk("alu_ack_idle_req", 71'(dm_req), 71'd0);
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 1'b1, 32'd0, 32'hCAFE0001, 5'd31});
        ex_valid = 1; alurslt = 32'hCAFE0001; wrreg = 31; regwrite = 0; memtoreg = 1; dm_ack = 0;
        @(negedge clk);
        chk("alu2_stall", 71'(stall), 71'd0);
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;

        // Load 0x100, ack in third WAIT cycle
        exp_q.push_back({1'b1, 1'b1, 32'hDEADBEEF, 32'h100, 5'd7});
        run_memop(1, 0, 32'h100, 32'h0, 7, 1, 1, 2, 32'hDEADBEEF, rq, st);
        chk("load_req_cycles", 71'(rq), 71'd3);
        chk("load_stall_cycles", 71'(st), 71'd3);

        // Store, ack in first WAIT cycle: regwrite suppressed, rdata forced 0
        exp_q.push_back({1'b0, 1'b0, 32'd0, 32'h44, 5'd9});
        run_memop(0, 1, 32'h44, 32'h12345678, 9, 1, 0, 0, 32'hFFFFFFFF, rq, st);
        chk("store_req_cycles", 71'(rq), 71'd1);
        chk("store_stall_cycles", 71'(st), 71'd1);

        // memread and memwrite together behave as a store
        exp_q.push_back({1'b0, 1'b1, 32'd0, 32'h80, 5'd4});
        run_memop(1, 1, 32'h80, 32'hA5A5A5A5, 4, 1, 1, 1, 32'h11111111, rq, st);
        chk("rdwr_req_cycles", 71'(rq), 71'd2);

        // Misaligned load
        run_memop(1, 0, 32'h102, 32'h0, 6, 1, 1, 0, 32'h22222222, rq, st);
        chk("mis_req_cycles", 71'(rq), 71'd0);
        chk("mis_stall_cycles", 71'(st), 71'd0);
        chk("mis_flags", {misalign_err, timeout_err}, 71'b10);

        // Load with no ack times out after TIMEOUT cycles
        run_memop(1, 0, 32'h200, 32'h0, 8, 1, 1, -1, 32'h0, rq, st);
        chk("to_req_cycles", 71'(rq), 71'd4);
        chk("to_stall_cycles", 71'(st), 71'd4);
        chk("to_flags", {misalign_err, timeout_err}, 71'b11);
        chk("to_idle_req", 71'(dm_req), 71'd0);

        // Reset asserted mid-WAIT with the load still presented
        ex_valid = 1; memread = 1; alurslt = 32'h400; wrreg = 5; regwrite = 1; memtoreg = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_req_before", 71'(dm_req), 71'd1);
        #2 reset_n = 0;
        #1;
        chk("rw_ctl", {stall, dm_req, dm_we, misalign_err, timeout_err}, 71'd0);
        chk("rw_dm", {dm_addr, dm_wdata}, 71'd0);
        chk("rw_wb", {regwrite_out, memtoreg_out, rdata, alurslt_out, wrreg_out}, 71'd0);
        clear_inputs();
        @(posedge clk);
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;

        exp_q.push_back({1'b1, 1'b1, 32'h0BADF00D, 32'h300, 5'd12});
        run_memop(1, 0, 32'h300, 32'h0, 12, 1, 1, 0, 32'h0BADF00D, rq, st);
        chk("post_rst_req_cycles", 71'(rq), 71'd1);
        chk("post_rst_flags", {misalign_err, timeout_err}, 71'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 71'(exp_q.size()), 71'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
